// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the initiator state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam logic [1:0] AXI_OK     = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_RESPOND
    } axil_state_e;

endpackage

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command port.
// Latency: AXI valids rise 1 cycle after cmd accept; rsp_valid 1 cycle after B/R handshake.
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready; slow responders flagged, never abandoned.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int AXI_LITE_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           m_axi_lite_aclk,
    input  logic                           axi_resetn,

    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                    cmd_wdata,

    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [31:0]                    rsp_rdata,
    output logic [1:0]                     rsp_resp,
    output logic                           bus_timeout,

    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
    output logic                           m_axi_lite_awvalid,
    input  logic                           m_axi_lite_awready,
    output logic [31:0]                    m_axi_lite_wdata,
    output logic                           m_axi_lite_wvalid,
    input  logic                           m_axi_lite_wready,
    input  logic [1:0]                     m_axi_lite_bresp,
    input  logic                           m_axi_lite_bvalid,
    output logic                           m_axi_lite_bready,
    output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
    output logic                           m_axi_lite_arvalid,
    input  logic                           m_axi_lite_arready,
    input  logic [31:0]                    m_axi_lite_rdata,
    input  logic [1:0]                     m_axi_lite_rresp,
    input  logic                           m_axi_lite_rvalid,
    output logic                           m_axi_lite_rready
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    axil_state_e                    state_q, state_d;
    logic [AXI_LITE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                    wdata_q, wdata_d;
    logic                           awvalid_q, awvalid_d;
    logic                           wvalid_q, wvalid_d;
    logic                           bready_q, bready_d;
    logic                           arvalid_q, arvalid_d;
    logic                           rready_q, rready_d;
    logic                           rsp_valid_q, rsp_valid_d;
    logic [31:0]                    rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                     rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]               tmo_cnt_q, tmo_cnt_d;
    logic [CNT_W-1:0]               tmo_cnt_inc;
    logic                           aw_fin;
    logic                           w_fin;

    // Saturating so bus_timeout holds however long the responder stalls.
    assign tmo_cnt_inc = (tmo_cnt_q == CNT_MAX) ? tmo_cnt_q : tmo_cnt_q + CNT_W'(1);

    // A channel counts as finished if it already handshook or handshakes now.
    assign aw_fin = !awvalid_q || m_axi_lite_awready;
    assign w_fin  = !wvalid_q  || m_axi_lite_wready;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    tmo_cnt_d = '0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR_ADDR_DATA;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR_ADDR_DATA: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (awvalid_q && m_axi_lite_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_lite_wready)   wvalid_d  = 1'b0;
                if (aw_fin && w_fin) begin
                    bready_d = 1'b1;
                    state_d  = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (m_axi_lite_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi_lite_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESPOND;
                end
            end
            ST_RD_ADDR: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (m_axi_lite_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                tmo_cnt_d = tmo_cnt_inc;
                if (m_axi_lite_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_axi_lite_rresp;
                    rsp_rdata_d = m_axi_lite_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    tmo_cnt_d   = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge m_axi_lite_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign cmd_ready          = (state_q == ST_IDLE);
    assign rsp_valid          = rsp_valid_q;
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_resp           = rsp_resp_q;
    assign bus_timeout        = (tmo_cnt_q == CNT_MAX);
    assign m_axi_lite_awaddr  = addr_q;
    assign m_axi_lite_awvalid = awvalid_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wvalid  = wvalid_q;
    assign m_axi_lite_bready  = bready_q;
    assign m_axi_lite_araddr  = addr_q;
    assign m_axi_lite_arvalid = arvalid_q;
    assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural AXI-Lite responder with per-channel delays,
// register-file reference model, directed corner cases and randomized traffic.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    localparam int AW  = 8;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        axi_resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        bus_timeout;
    logic [AW-1:0] awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;

    axi_lite_master #(.AXI_LITE_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .m_axi_lite_aclk(clk), .axi_resetn(axi_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .bus_timeout(bus_timeout),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
        .m_axi_lite_rready(rready)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Responder knobs and statistics
    int aw_dly = 0, w_dly = 0, b_dly = 1, ar_dly = 0, r_dly = 1;
    bit force_r = 1'b0;
    logic [1:0]  force_rresp = 2'b00;
    logic [31:0] force_rdata = 32'h0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    int aw_hi = 0, w_hi = 0;
    logic [31:0] mem [0:63];

    function automatic bit slverr(input logic [AW-1:0] a);
        return a[7:4] == 4'hF;
    endfunction

    // Behavioural responder plus valid-hold protocol monitor; runs at negedge.
    initial begin
        bit have_aw, have_w, have_ar, b_armed, r_armed;
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit p_aw_st, p_w_st, p_ar_st;
        int aw_wait, w_wait, ar_wait, b_gap, r_gap;
        logic [AW-1:0] hs_awaddr, hs_araddr, wr_addr, rd_addr, p_awaddr, p_araddr;
        logic [31:0] hs_wdata, wr_data, p_wdata;
        logic [1:0] b_code;
        {have_aw, have_w, have_ar, b_armed, r_armed} = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, p_aw_st, p_w_st, p_ar_st} = '0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_gap = 0; r_gap = 0;
        hs_awaddr = '0; hs_araddr = '0; wr_addr = '0; rd_addr = '0;
        p_awaddr = '0; p_araddr = '0; hs_wdata = '0; wr_data = '0; p_wdata = '0; b_code = '0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = '0; rresp = '0; rdata = '0;
        forever begin
            @(negedge clk);
            if (!axi_resetn) begin
                {have_aw, have_w, have_ar, b_armed, r_armed} = '0;
                {aw_hs, w_hs, b_hs, ar_hs, r_hs, p_aw_st, p_w_st, p_ar_st} = '0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                continue;
            end
            if (aw_hs) begin have_aw = 1; wr_addr = hs_awaddr; n_aw++; aw_wait = 0; end
            if (w_hs)  begin have_w = 1;  wr_data = hs_wdata;  n_w++;  w_wait = 0;  end
            if (b_hs)  begin bvalid = 0; n_b++; end
            if (ar_hs) begin have_ar = 1; rd_addr = hs_araddr; n_ar++; ar_wait = 0; end
            if (r_hs)  begin rvalid = 0; n_r++; end
            if (have_aw && have_w) begin
                if (!slverr(wr_addr)) mem[wr_addr[7:2]] = wr_data;
                b_code = slverr(wr_addr) ? AXI_SLVERR : AXI_OK;
                have_aw = 0; have_w = 0; b_armed = 1; b_gap = b_dly;
            end
            if (b_armed) begin
                if (b_gap == 0) begin bvalid = 1; bresp = b_code; b_armed = 0; end
                else b_gap--;
            end
            if (have_ar) begin have_ar = 0; r_armed = 1; r_gap = r_dly; end
            if (r_armed) begin
                if (r_gap == 0) begin
                    rvalid = 1; r_armed = 0;
                    if (force_r) begin rresp = force_rresp; rdata = force_rdata; end
                    else if (slverr(rd_addr)) begin rresp = AXI_SLVERR; rdata = '0; end
                    else begin rresp = AXI_OK; rdata = mem[rd_addr[7:2]]; end
                end else r_gap--;
            end
            awready = awvalid && !have_aw && (aw_wait >= aw_dly);
            if (awvalid && !awready && !have_aw) aw_wait++;
            wready = wvalid && !have_w && (w_wait >= w_dly);
            if (wvalid && !wready && !have_w) w_wait++;
            arready = arvalid && (ar_wait >= ar_dly);
            if (arvalid && !arready) ar_wait++;
            aw_hs = awvalid && awready; hs_awaddr = awaddr;
            w_hs  = wvalid && wready;   hs_wdata  = wdata;
            ar_hs = arvalid && arready; hs_araddr = araddr;
            b_hs  = bvalid && bready;
            r_hs  = rvalid && rready;
            if (awvalid) aw_hi++;
            if (wvalid)  w_hi++;
            if (p_aw_st) begin
                chk("awvalid_hold", 32'(awvalid), 32'd1);
                chk("awaddr_stable", 32'(awaddr), 32'(p_awaddr));
            end
            if (p_w_st) begin
                chk("wvalid_hold", 32'(wvalid), 32'd1);
                chk("wdata_stable", wdata, p_wdata);
            end
            if (p_ar_st) begin
                chk("arvalid_hold", 32'(arvalid), 32'd1);
                chk("araddr_stable", 32'(araddr), 32'(p_araddr));
            end
            p_aw_st = awvalid && !awready; p_awaddr = awaddr;
            p_w_st  = wvalid && !wready;   p_wdata  = wdata;
            p_ar_st = arvalid && !arready; p_araddr = araddr;
        end
    end

    // Reference register file: what the initiator must report back.
    logic [31:0] ref_mem [0:63];

    task automatic send_cmd(input bit w, input logic [AW-1:0] a, input logic [31:0] d, output int t_acc);
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        t_acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin t_acc = cyc; break; end
            @(negedge clk);
        end
        if (t_acc < 0) chk("cmd_accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int t_rsp);
        t_rsp = -1;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid) begin t_rsp = cyc; break; end
            @(negedge clk);
        end
        if (t_rsp < 0) chk("rsp_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input string tag, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                          input bit check_lat, input int rdy_dly);
        int t_acc, t_rsp;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        exp_r = slverr(a) ? AXI_SLVERR : AXI_OK;
        if (w) begin
            exp_d = '0;
            if (!slverr(a)) ref_mem[a[7:2]] = d;
        end else begin
            exp_d = slverr(a) ? 32'h0 : ref_mem[a[7:2]];
        end
        send_cmd(w, a, d, t_acc);
        wait_rsp(t_rsp);
        if (check_lat) chk({tag, "_latency"}, 32'(t_rsp - t_acc), 32'd4);
        repeat (rdy_dly) @(negedge clk);
        chk({tag, "_rdata"}, rsp_rdata, exp_d);
        chk({tag, "_resp"}, 32'(rsp_resp), 32'(exp_r));
        take_rsp();
    endtask

    initial begin
        int t_acc, t_rsp, t_hs, b_aw, b_w, b_b;
        for (int i = 0; i < 64; i++) begin mem[i] = '0; ref_mem[i] = '0; end
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 0;
        axi_resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_bus_timeout", 32'(bus_timeout), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);
        #2 axi_resetn = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Pixel-generator-like responder timing
        do_txn("pg_write", 1'b1, 8'h04, 32'hDEADBEEF, 1'b1, 0);
        do_txn("pg_read", 1'b0, 8'h04, 32'h0, 1'b1, 0);

        // W accepted at once, AW stalled six cycles
        aw_dly = 6; w_dly = 0; b_dly = 0;
        b_aw = n_aw; b_w = n_w; b_b = n_b; aw_hi = 0; w_hi = 0;
        do_txn("aw_slow", 1'b1, 8'h08, 32'hA5A5_5A5A, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("aw_slow_awvalid_cycles", 32'(aw_hi), 32'd7);
        chk("aw_slow_wvalid_cycles", 32'(w_hi), 32'd1);
        chk("aw_slow_n_aw", 32'(n_aw - b_aw), 32'd1);
        chk("aw_slow_n_w", 32'(n_w - b_w), 32'd1);
        chk("aw_slow_n_b", 32'(n_b - b_b), 32'd1);
        aw_dly = 0; b_dly = 1;

        // Error response with data passes straight through
        force_r = 1'b1; force_rresp = 2'b10; force_rdata = 32'h12345678;
        send_cmd(1'b0, 8'h0C, 32'h0, t_acc);
        wait_rsp(t_rsp);
        chk("slverr_rdata", rsp_rdata, 32'h12345678);
        chk("slverr_resp", 32'(rsp_resp), 32'h2);
        take_rsp();
        force_r = 1'b0;

        // Response backpressure with a new command waiting
        ref_mem[4] = 32'hCAFE_0010;
        send_cmd(1'b1, 8'h10, 32'hCAFE_0010, t_acc);
        wait_rsp(t_rsp);
        cmd_write = 1'b0; cmd_addr = 8'h10; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'd0);
            chk("hold_rsp_resp", 32'(rsp_resp), 32'd0);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        t_hs = cyc;
        take_rsp();
        send_cmd(1'b0, 8'h10, 32'h0, t_acc);
        chk("b2b_accept_cycle", 32'(t_acc), 32'(t_hs + 1));
        wait_rsp(t_rsp);
        chk("b2b_rdata", rsp_rdata, 32'hCAFE_0010);
        take_rsp();

        // Slow AR: timeout flag rises after TMO wait cycles, transfer still completes
        ar_dly = 20; r_dly = 0;
        send_cmd(1'b0, 8'h04, 32'h0, t_acc);
        for (int n = 1; n <= 21; n++) begin
            chk("tmo_arvalid", 32'(arvalid), 32'd1);
            chk($sformatf("tmo_flag_c%0d", n), 32'(bus_timeout), 32'((n - 1) >= TMO));
            @(negedge clk);
        end
        wait_rsp(t_rsp);
        chk("tmo_flag_respond", 32'(bus_timeout), 32'd1);
        chk("tmo_rdata", rsp_rdata, 32'hDEADBEEF);
        take_rsp();
        chk("tmo_flag_idle", 32'(bus_timeout), 32'd0);
        chk("tmo_cmd_ready", 32'(cmd_ready), 32'd1);
        ar_dly = 0; r_dly = 1;

        // Reset while waiting for B
        b_dly = 10;
        ref_mem[8] = 32'h0BAD_CAFE;
        send_cmd(1'b1, 8'h20, 32'h0BAD_CAFE, t_acc);
        for (int i = 0; i < 20 && !bready; i++) @(negedge clk);
        chk("mid_rst_in_wr_resp", 32'(bready), 32'd1);
        @(negedge clk);
        #2 axi_resetn = 1'b0;
        #1;
        chk("mid_rst_awvalid", 32'(awvalid), 32'd0);
        chk("mid_rst_wvalid", 32'(wvalid), 32'd0);
        chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rst_bready", 32'(bready), 32'd0);
        chk("mid_rst_rready", 32'(rready), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        #2 axi_resetn = 1'b1;
        b_dly = 1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        do_txn("post_rst_read", 1'b0, 8'h04, 32'h0, 1'b1, 0);
        do_txn("post_rst_read2", 1'b0, 8'h20, 32'h0, 1'b1, 0);

        // Randomized traffic against the reference register file
        for (int k = 0; k < 40; k++) begin
            logic [AW-1:0] a;
            logic [3:0]    widx;
            logic [1:0]    hidx;
            widx = 4'($urandom_range(0, 15));
            hidx = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 7) == 0) ? {4'hF, hidx, 2'b00} : {2'b00, widx, 2'b00};
            aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
            b_dly  = $urandom_range(0, 3); ar_dly = $urandom_range(0, 3);
            r_dly  = $urandom_range(0, 3);
            do_txn($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), a, $urandom, 1'b0,
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
